manycore_endpoint_core: RTL and testbench



---
 rtl/manycore_endpoint_pkg.sv | 37 +++
 rtl/manycore_endpoint_req_fifo.sv | 69 ++++++
 rtl/manycore_endpoint_core.sv | 117 +++++++++++
 tb/tb_manycore_endpoint_core.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/manycore_endpoint_pkg.sv
// Shared definitions for the manycore endpoint: opcode and return-type
// encodings, plus the width functions that size packets and the link bundle.
// Optional build macro: MANYCORE_ENDPOINT_ASSERT_EN (simulation checks).
package manycore_endpoint_pkg;

  // Request opcode carried in packet.op.
  typedef enum logic [1:0] {
    op_remote_load  = 2'd0,
    op_remote_store = 2'd1,
    op_swap_aq      = 2'd2,
    op_swap_rl      = 2'd3
  } op_e;

  // Return packet type carried in return_packet.pkt_type.
  typedef enum logic [1:0] {
    ret_credit = 2'd0,
    ret_data   = 2'd1
  } ret_type_e;

  // Request packet: addr, op[2], op_ex[data/8], payload, src_y, src_x, y, x.
  function automatic int packet_width(input int x_w, input int y_w,
                                      input int data_w, input int addr_w);
    return addr_w + 2 + data_w / 8 + data_w + 2 * (x_w + y_w);
  endfunction

  // Return packet: pkt_type[2], data, load_id, y, x.
  function automatic int return_width(input int x_w, input int y_w,
                                      input int data_w, input int load_id_w);
    return 2 + data_w + load_id_w + x_w + y_w;
  endfunction

  // Link bundle: fwd{v, data[P], ready_and_rev}, rev{v, data[R], ready_and_rev}.
  function automatic int link_width(input int pkt_w, input int ret_w);
    return pkt_w + ret_w + 4;
  endfunction

endpackage

// File: rtl/manycore_endpoint_req_fifo.sv
// Parameterised width/depth 1-read 1-write FIFO with a ready/valid enqueue
// side and a valid/yumi dequeue side. No bypass: a word written in cycle N is
// visible on data_o/v_o in cycle N+1. Enqueue is refused whenever the FIFO is
// full, even if a dequeue happens in the same cycle.
//
// Handshake: a word is accepted when v_i & ready_o at the clock edge; a word
// is consumed when yumi_i & v_o at the clock edge (yumi_i without v_o is
// ignored).
module manycore_endpoint_req_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,
  output logic               full_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_r;
  logic [ptr_w_lp-1:0] rd_ptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                enq;
  logic                deq;

  assign full_o  = (count_r == cnt_w_lp'(els_p));
  assign ready_o = ~full_o;
  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rd_ptr_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  // Pointer and occupancy update; pointers wrap modulo els_p.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_r + 1'b1;
      end
      if (deq) begin
        rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_r + 1'b1;
      end
      if (enq && !deq) begin
        count_r <= count_r + 1'b1;
      end else if (deq && !enq) begin
        count_r <= count_r - 1'b1;
      end
    end
  end

  // Storage array; contents need no reset because count_r gates visibility.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

endmodule

// File: rtl/manycore_endpoint_core.sv
// Tile network interface between the two-net mesh link and tile logic.
// Incoming requests are buffered in a local FIFO; outgoing requests and
// locally built return packets pass straight through to the link; return
// packets arriving on the reverse net are registered for one cycle.
// Optional build macro: MANYCORE_ENDPOINT_ASSERT_EN enables simulation-only
// protocol checks; the datapath is identical either way.
import manycore_endpoint_pkg::*;

module manycore_endpoint_core #(
  parameter int x_cord_width_p  = 4,
  parameter int y_cord_width_p  = 4,
  parameter int fifo_els_p      = 2,
  parameter int data_width_p    = 32,
  parameter int addr_width_p    = 32,
  parameter int load_id_width_p = 5,
  localparam int pkt_w_lp  = packet_width(x_cord_width_p, y_cord_width_p,
                                          data_width_p, addr_width_p),
  localparam int ret_w_lp  = return_width(x_cord_width_p, y_cord_width_p,
                                          data_width_p, load_id_width_p),
  localparam int link_w_lp = link_width(pkt_w_lp, ret_w_lp)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [link_w_lp-1:0] link_sif_i,
  output logic [link_w_lp-1:0] link_sif_o,
  output logic [pkt_w_lp-1:0]  fifo_data_o,
  output logic                 fifo_v_o,
  input  logic                 fifo_yumi_i,
  input  logic [pkt_w_lp-1:0]  out_packet_i,
  input  logic                 out_v_i,
  output logic                 out_ready_o,
  input  logic [ret_w_lp-1:0]  returning_data_i,
  input  logic                 returning_v_i,
  output logic                 returning_ready_o,
  output logic [ret_w_lp-1:0]  returned_packet_r_o,
  output logic                 returned_credit_v_r_o,
  output logic                 in_fifo_full_o
);

  // Link unpacking. Forward half occupies the upper R+2..L-1 bits, reverse
  // half the lower R+2 bits; within each half: v (MSB), data, ready (LSB).
  logic                fwd_v_in;
  logic [pkt_w_lp-1:0] fwd_data_in;
  logic                fwd_ready_in;
  logic                rev_v_in;
  logic [ret_w_lp-1:0] rev_data_in;
  logic                rev_ready_in;
  logic                fifo_ready;

  assign fwd_v_in     = link_sif_i[link_w_lp-1];
  assign fwd_data_in  = link_sif_i[link_w_lp-2 -: pkt_w_lp];
  assign fwd_ready_in = link_sif_i[ret_w_lp+2];
  assign rev_v_in     = link_sif_i[ret_w_lp+1];
  assign rev_data_in  = link_sif_i[ret_w_lp:1];
  assign rev_ready_in = link_sif_i[0];

  // Incoming request buffer.
  manycore_endpoint_req_fifo #(
    .width_p (pkt_w_lp),
    .els_p   (fifo_els_p)
  ) req_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (fwd_data_in),
    .v_i     (fwd_v_in),
    .ready_o (fifo_ready),
    .data_o  (fifo_data_o),
    .v_o     (fifo_v_o),
    .yumi_i  (fifo_yumi_i),
    .full_o  (in_fifo_full_o)
  );

  // Outgoing requests and return packets are pure wiring; the reverse-net
  // ready is tied high because the tile must always sink return packets.
  assign link_sif_o = {out_v_i, out_packet_i, fifo_ready,
                       returning_v_i, returning_data_i, 1'b1};

  assign out_ready_o       = fwd_ready_in;
  assign returning_ready_o = rev_ready_in;

  // Register every received return packet for one cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      returned_credit_v_r_o <= 1'b0;
      returned_packet_r_o   <= '0;
    end else begin
      returned_credit_v_r_o <= rev_v_in;
      returned_packet_r_o   <= rev_data_in;
    end
  end

`ifdef MANYCORE_ENDPOINT_ASSERT_EN
  // Depth sanity check at start of simulation.
  initial begin
    if (fifo_els_p < 2) begin
      $error("manycore_endpoint_core: fifo_els_p=%0d must be >= 2", fifo_els_p);
    end
  end

  // Runtime protocol checks outside reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (fifo_yumi_i && !fifo_v_o) begin
        $error("manycore_endpoint_core: fifo_yumi_i asserted while fifo empty");
      end
      if (fwd_v_in && $isunknown(fwd_data_in)) begin
        $error("manycore_endpoint_core: fwd valid with unknown data");
      end
    end
  end
`else
  // Reverse-net ready from the link is not meaningful to this block's sink.
  logic unused_ok;
  assign unused_ok = 1'b0;
`endif

endmodule

// File: tb/tb_manycore_endpoint_core.sv
// Directed self-checking bench for manycore_endpoint_core.
import manycore_endpoint_pkg::*;

module tb_manycore_endpoint_core;

  localparam int xw  = 4;
  localparam int yw  = 4;
  localparam int els = 4;
  localparam int dw  = 32;
  localparam int aw  = 32;
  localparam int lw  = 5;
  localparam int pw  = packet_width(xw, yw, dw, aw);
  localparam int rw  = return_width(xw, yw, dw, lw);
  localparam int kw  = link_width(pw, rw);

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // link fields driven by the bench
  logic          fwd_v = 0, fwd_ready = 0, rev_v = 0, rev_ready = 0;
  logic [pw-1:0] fwd_data = '0;
  logic [rw-1:0] rev_data = '0;
  logic [kw-1:0] link_in, link_out;
  assign link_in = {fwd_v, fwd_data, fwd_ready, rev_v, rev_data, rev_ready};

  logic [pw-1:0] fifo_data, out_packet = '0;
  logic          fifo_v, fifo_yumi = 0, out_v = 0, out_ready;
  logic [rw-1:0] returning_data = '0, returned_packet;
  logic          returning_v = 0, returning_ready, returned_v, full;

  // link_out unpacked for checking
  logic          o_fwd_v, o_fwd_ready, o_rev_v, o_rev_ready;
  logic [pw-1:0] o_fwd_data;
  logic [rw-1:0] o_rev_data;
  assign {o_fwd_v, o_fwd_data, o_fwd_ready, o_rev_v, o_rev_data, o_rev_ready} = link_out;

  manycore_endpoint_core #(
    .x_cord_width_p (xw), .y_cord_width_p (yw), .fifo_els_p (els),
    .data_width_p (dw), .addr_width_p (aw), .load_id_width_p (lw)
  ) dut (
    .clk_i (clk), .reset_i (reset),
    .link_sif_i (link_in), .link_sif_o (link_out),
    .fifo_data_o (fifo_data), .fifo_v_o (fifo_v), .fifo_yumi_i (fifo_yumi),
    .out_packet_i (out_packet), .out_v_i (out_v), .out_ready_o (out_ready),
    .returning_data_i (returning_data), .returning_v_i (returning_v),
    .returning_ready_o (returning_ready),
    .returned_packet_r_o (returned_packet), .returned_credit_v_r_o (returned_v),
    .in_fifo_full_o (full)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [pw-1:0] exp_q[$];

  function automatic logic [pw-1:0] make_pkt(input logic [31:0] addr, input op_e op,
                                             input logic [31:0] payload);
    return {addr, op, 4'hF, payload, 4'd0, 4'd0, 4'd1, 4'd1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fifo_v !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_v got %b exp 0", fifo_v); end
    n_checks++;
    if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
    n_checks++;
    if (o_fwd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_fwd_ready got %b exp 1", o_fwd_ready); end
    n_checks++;
    if (returned_v !== 1'b0) begin n_fail++; $display("FAIL reset_ret_v got %b exp 0", returned_v); end
    n_checks++;
    if (returned_packet !== '0) begin n_fail++; $display("FAIL reset_ret_pkt got %h exp 0", returned_packet); end
    n_checks++;
    if (o_rev_ready !== 1'b1) begin n_fail++; $display("FAIL rev_ready_tied got %b exp 1", o_rev_ready); end
    step();
  endtask

  task automatic test_single();
    logic [pw-1:0] p;
    p = make_pkt(32'h10, op_remote_store, 32'hDEADBEEF);
    fwd_v = 1'b1;
    fwd_data = p;
    @(negedge clk);
    n_checks++;
    if (fifo_v !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got %b exp 0", fifo_v); end
    step();
    fwd_v = 1'b0;
    fwd_data = '0;
    @(negedge clk);
    n_checks++;
    if (fifo_v !== 1'b1) begin n_fail++; $display("FAIL single_v got %b exp 1", fifo_v); end
    n_checks++;
    if (fifo_data !== p) begin n_fail++; $display("FAIL single_data got %h exp %h", fifo_data, p); end
    fifo_yumi = 1'b1;
    step();
    fifo_yumi = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fifo_v !== 1'b0) begin n_fail++; $display("FAIL single_empty got %b exp 0", fifo_v); end
    step();
  endtask

  task automatic test_fill();
    logic [pw-1:0] p;
    fwd_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fwd_data = make_pkt(32'h20 + i, op_remote_load, 32'h1 + i);
      @(negedge clk);
      n_checks++;
      if (o_fwd_ready !== (i < 4)) begin
        n_fail++; $display("FAIL fill_ready[%0d] got %b exp %b", i, o_fwd_ready, (i < 4));
      end
      n_checks++;
      if (full !== (i == 4)) begin
        n_fail++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, (i == 4));
      end
      step();
    end
    fwd_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p = make_pkt(32'h20 + i, op_remote_load, 32'h1 + i);
      @(negedge clk);
      n_checks++;
      if (fifo_v !== 1'b1 || fifo_data !== p) begin
        n_fail++; $display("FAIL drain[%0d] got v=%b %h exp v=1 %h", i, fifo_v, fifo_data, p);
      end
      fifo_yumi = 1'b1;
      step();
      fifo_yumi = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (fifo_v !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b exp 0", fifo_v); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [pw-1:0] p;
    fwd_v = 1'b1;
    for (int i = 0; i < 2; i++) begin
      p = make_pkt(32'h100 + i, op_swap_aq, 32'hA000_0000 + i);
      fwd_data = p;
      exp_q.push_back(p);
      step();
    end
    fifo_yumi = 1'b1;
    for (int i = 2; i < 12; i++) begin
      p = make_pkt(32'h100 + i, op_swap_rl, 32'hA000_0000 + i);
      fwd_data = p;
      @(negedge clk);
      n_checks++;
      if (fifo_v !== 1'b1 || fifo_data !== exp_q[0] || full !== 1'b0) begin
        n_fail++; $display("FAIL b2b[%0d] got v=%b full=%b %h exp %h", i, fifo_v, full, fifo_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      exp_q.push_back(p);
      step();
    end
    fwd_v = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (fifo_v !== 1'b1 || fifo_data !== exp_q[0]) begin
        n_fail++; $display("FAIL b2b_tail[%0d] got v=%b %h exp %h", i, fifo_v, fifo_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      step();
    end
    fifo_yumi = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fifo_v !== 1'b0) begin n_fail++; $display("FAIL b2b_count got v=%b exp 0", fifo_v); end
    step();
  endtask

  task automatic test_passthrough();
    logic [pw-1:0] p;
    logic [rw-1:0] r;
    p = make_pkt(32'h3000, op_remote_load, 32'h12345678);
    r = {2'd0, 32'h0BADF00D, 5'd7, 4'd3, 4'd5};
    out_v = 1'b1; out_packet = p; fwd_ready = 1'b0;
    returning_v = 1'b1; returning_data = r; rev_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_ready !== 1'b0) begin n_fail++; $display("FAIL out_ready_lo got %b exp 0", out_ready); end
    n_checks++;
    if (o_fwd_v !== 1'b1 || o_fwd_data !== p) begin
      n_fail++; $display("FAIL out_fwd got v=%b %h exp v=1 %h", o_fwd_v, o_fwd_data, p);
    end
    n_checks++;
    if (returning_ready !== 1'b0) begin n_fail++; $display("FAIL ret_ready_lo got %b exp 0", returning_ready); end
    n_checks++;
    if (o_rev_v !== 1'b1 || o_rev_data !== r) begin
      n_fail++; $display("FAIL out_rev got v=%b %h exp v=1 %h", o_rev_v, o_rev_data, r);
    end
    fwd_ready = 1'b1; rev_ready = 1'b1;
    #1;
    n_checks++;
    if (out_ready !== 1'b1) begin n_fail++; $display("FAIL out_ready_hi got %b exp 1", out_ready); end
    n_checks++;
    if (returning_ready !== 1'b1) begin n_fail++; $display("FAIL ret_ready_hi got %b exp 1", returning_ready); end
    step();
    out_v = 1'b0; returning_v = 1'b0; fwd_ready = 1'b0; rev_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_fwd_v !== 1'b0 || o_rev_v !== 1'b0) begin
      n_fail++; $display("FAIL out_v_lo got fwd=%b rev=%b exp 0 0", o_fwd_v, o_rev_v);
    end
    step();
  endtask

  task automatic test_returned();
    logic [rw-1:0] r;
    r = {2'd1, 32'hCAFEF00D, 5'd3, 4'd1, 4'd2};
    rev_v = 1'b1; rev_data = r;
    @(negedge clk);
    n_checks++;
    if (returned_v !== 1'b0) begin n_fail++; $display("FAIL ret_early got %b exp 0", returned_v); end
    step();
    rev_v = 1'b0; rev_data = '0;
    @(negedge clk);
    n_checks++;
    if (returned_v !== 1'b1 || returned_packet !== r) begin
      n_fail++; $display("FAIL ret_pkt got v=%b %h exp v=1 %h", returned_v, returned_packet, r);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (returned_v !== 1'b0 || returned_packet !== '0) begin
      n_fail++; $display("FAIL ret_after got v=%b %h exp v=0 0", returned_v, returned_packet);
    end
    step();
  endtask

  task automatic test_reset_mid();
    fwd_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fwd_data = make_pkt(32'h500 + i, op_remote_store, 32'h55 + i);
      step();
    end
    fwd_v = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fifo_v !== 1'b1) begin n_fail++; $display("FAIL mid_queued got %b exp 1", fifo_v); end
    reset = 1'b1;
    rev_v = 1'b1; rev_data = {2'd1, 32'h1, 5'd1, 4'd1, 4'd1};
    step();
    reset = 1'b0;
    rev_v = 1'b0; rev_data = '0;
    @(negedge clk);
    n_checks++;
    if (fifo_v !== 1'b0 || full !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_fifo got v=%b full=%b exp 0 0", fifo_v, full);
    end
    n_checks++;
    if (returned_v !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ret got %b exp 0", returned_v); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_passthrough();
    test_returned();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
